tick_period_meter: RTL and testbench

- Receive-side companion to the tick generator.
- The generator turns a terminal count into a periodic one-cycle tick; this block does the reverse: it measures the clk-cycle interval between rising edges of a tick input and reports it as a count.
- Also flags loss of tick (timeout) and period stability (locked).
- Sits beside tick consumers for self-check and bring-up; tick_in is in the clk domain, so there is no synchronizer.

---
 rtl/tick_period_meter.sv | 117 +++++++++++
 tb/tb_tick_period_meter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_period_meter.sv
// Measures the clk-cycle interval between rising edges of tick_in; flags timeout and lock.
// Optional min/max period tracking is compiled in when TICK_PERIOD_MINMAX_EN is defined.
module tick_period_meter #(
    parameter int WIDTH = 20,
    parameter int TOL   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
`ifdef TICK_PERIOD_MINMAX_EN
    input  logic             minmax_clr,
    output logic [WIDTH-1:0] period_min,
    output logic [WIDTH-1:0] period_max,
`endif
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic [1:0] {IDLE, MEASURE, LOST} state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   TOL_W   = (WIDTH+1)'(TOL);

    state_t           r_state;
    logic             r_tick_d;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_prev;

    logic             w_edge;
    logic [WIDTH:0]   w_diff;
    logic             w_in_tol;

    assign w_edge = tick_in & ~r_tick_d;

    // Absolute difference at WIDTH+1 bits so it can never wrap.
    always_comb begin
        w_diff = '0;
        if (r_cnt >= r_prev)
            w_diff = {1'b0, r_cnt} - {1'b0, r_prev};
        else
            w_diff = {1'b0, r_prev} - {1'b0, r_cnt};
    end

    assign w_in_tol = (w_diff <= TOL_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_tick_d     <= 1'b0;
            r_cnt        <= '0;
            r_prev       <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            r_tick_d     <= tick_in;
            period_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_edge) begin
                        r_cnt   <= CNT_ONE;
                        r_state <= MEASURE;
                    end
                end
                MEASURE: begin
                    // An edge on the terminal count still reports; it beats the timeout.
                    if (w_edge) begin
                        period       <= r_cnt;
                        period_valid <= 1'b1;
                        r_cnt        <= CNT_ONE;
                        r_prev       <= r_cnt;
                        if (r_prev != '0)
                            locked <= w_in_tol;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state <= LOST;
                        timeout <= 1'b1;
                        locked  <= 1'b0;
                        r_prev  <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                LOST: begin
                    if (w_edge) begin
                        timeout <= 1'b0;
                        r_cnt   <= CNT_ONE;
                        r_state <= MEASURE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef TICK_PERIOD_MINMAX_EN
    // Clear wins over an update landing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_min <= '1;
            period_max <= '0;
        end else if (minmax_clr) begin
            period_min <= '1;
            period_max <= '0;
        end else if (r_state == MEASURE && w_edge) begin
            if (r_cnt < period_min)
                period_min <= r_cnt;
            if (r_cnt > period_max)
                period_max <= r_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_tick_period_meter.sv
// Bench for tick_period_meter: two instances (TOL=0 and TOL=2, WIDTH=8) fed the same
// tick stream and checked against a timestamp-based reference model.
module tb_tick_period_meter;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tick_in = 1'b0;
    logic         minmax_clr = 1'b0;
    logic [W-1:0] d0_period, d2_period;
    logic         d0_pv, d0_lk, d0_to, d2_pv, d2_lk, d2_to;
`ifdef TICK_PERIOD_MINMAX_EN
    logic [W-1:0] d0_min, d0_max, d2_min, d2_max;
`endif

    always #5 clk = ~clk;

    tick_period_meter #(.WIDTH(W), .TOL(0)) dut0 (
        .clk(clk), .rst(rst), .tick_in(tick_in),
`ifdef TICK_PERIOD_MINMAX_EN
        .minmax_clr(minmax_clr), .period_min(d0_min), .period_max(d0_max),
`endif
        .period(d0_period), .period_valid(d0_pv), .locked(d0_lk), .timeout(d0_to)
    );

    tick_period_meter #(.WIDTH(W), .TOL(2)) dut2 (
        .clk(clk), .rst(rst), .tick_in(tick_in),
`ifdef TICK_PERIOD_MINMAX_EN
        .minmax_clr(minmax_clr), .period_min(d2_min), .period_max(d2_max),
`endif
        .period(d2_period), .period_valid(d2_pv), .locked(d2_lk), .timeout(d2_to)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: remembers the cycle number of the last edge rather than a counter.
    int m_now, m_tlast, m_period, m_prevp, m_min, m_max;
    bit m_armed, m_ptick, m_pv, m_to, m_lk0, m_lk2;
    int n_pv, last_p;

    task automatic model_reset();
        m_now = 0; m_tlast = 0; m_armed = 0; m_ptick = 0;
        m_pv = 0; m_to = 0; m_lk0 = 0; m_lk2 = 0;
        m_period = 0; m_prevp = 0; m_min = (1 << W) - 1; m_max = 0;
        n_pv = 0; last_p = 0;
    endtask

    task automatic model_step(input bit t, input bit clr);
        bit e;
        int p, d;
        m_now++;
        e = t && !m_ptick;
        m_ptick = t;
        m_pv = 0;
        if (e) begin
            if (m_armed) begin
                p = m_now - m_tlast;
                m_period = p;
                m_pv = 1;
                d = (p > m_prevp) ? p - m_prevp : m_prevp - p;
                if (m_prevp != 0) begin
                    m_lk0 = (d <= 0);
                    m_lk2 = (d <= 2);
                end
                m_prevp = p;
                if (p < m_min) m_min = p;
                if (p > m_max) m_max = p;
            end
            m_tlast = m_now;
            m_armed = 1;
            m_to = 0;
        end else if (m_armed && (m_now - m_tlast) == (1 << W) - 1) begin
            m_to = 1; m_lk0 = 0; m_lk2 = 0; m_prevp = 0; m_armed = 0;
        end
        if (clr) begin
            m_min = (1 << W) - 1;
            m_max = 0;
        end
    endtask

    // Drive one cycle of tick_in; outputs are sampled on the following falling edge.
    task automatic cyc(input bit t);
        tick_in = t;
        @(posedge clk);
        model_step(t, minmax_clr);
        @(negedge clk);
        if (d0_pv) begin
            n_pv++;
            last_p = d0_period;
        end
    endtask

    task automatic gap(input int n);
        cyc(1'b1);
        repeat (n - 1) cyc(1'b0);
    endtask

    task automatic do_reset(input bit t);
        @(negedge clk);
        rst = 1'b1;
        tick_in = t;
        minmax_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({d0_period, d0_pv, d0_lk, d0_to} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h/%b/%b/%b, need 0/0/0/0", d0_period, d0_pv, d0_lk, d0_to);
        end
        do_reset(1'b0);
    endtask

    task automatic test_basic();
        do_reset(1'b0);
        gap(10);
        cyc(1'b1);
        checks++;
        if (d0_pv !== 1'b1 || d0_period !== 8'd10 || n_pv != 1) begin
            errors++;
            $display("FAIL basic_first: pv=%b period=%0d n_pv=%0d, need pv=1 period=10 n_pv=1", d0_pv, d0_period, n_pv);
        end
        checks++;
        if (d0_lk !== 1'b0) begin
            errors++;
            $display("FAIL basic_lock1: locked=%b, need 0", d0_lk);
        end
        repeat (9) cyc(1'b0);
        cyc(1'b1);
        checks++;
        if (d0_pv !== 1'b1 || d0_period !== 8'd10 || d0_lk !== 1'b1) begin
            errors++;
            $display("FAIL basic_second: pv=%b period=%0d locked=%b, need 1/10/1", d0_pv, d0_period, d0_lk);
        end
    endtask

    task automatic test_lock();
        do_reset(1'b0);
        gap(10); gap(10); gap(12);
        checks++;
        if (d0_lk !== 1'b1 || d2_lk !== 1'b1) begin
            errors++;
            $display("FAIL lock_set: tol0=%b tol2=%b, need 1/1", d0_lk, d2_lk);
        end
        cyc(1'b1);
        checks++;
        if (d0_period !== 8'd12 || d0_pv !== 1'b1 || d0_lk !== 1'b0 || d2_lk !== 1'b1) begin
            errors++;
            $display("FAIL lock_drift: period=%0d pv=%b tol0=%b tol2=%b, need 12/1/0/1", d0_period, d0_pv, d0_lk, d2_lk);
        end
    endtask

    task automatic test_timeout();
        int k;
        int snap;
        do_reset(1'b0);
        gap(5);
        cyc(1'b1);
        k = 0;
        while (d0_to !== 1'b1 && k < 300) begin
            cyc(1'b0);
            k++;
        end
        checks++;
        if (k != 255 || d0_lk !== 1'b0 || d0_period !== 8'd5) begin
            errors++;
            $display("FAIL timeout_delay: cycles=%0d locked=%b period=%0d, need 255/0/5", k, d0_lk, d0_period);
        end
        repeat (3) cyc(1'b0);
        snap = n_pv;
        cyc(1'b1);
        checks++;
        if (d0_to !== 1'b0 || n_pv != snap) begin
            errors++;
            $display("FAIL timeout_clear: timeout=%b valids=%0d, need 0 and %0d", d0_to, n_pv, snap);
        end
        repeat (6) cyc(1'b0);
        cyc(1'b1);
        checks++;
        if (d0_pv !== 1'b1 || d0_period !== 8'd7) begin
            errors++;
            $display("FAIL timeout_resume: pv=%b period=%0d, need 1/7", d0_pv, d0_period);
        end
        repeat (254) cyc(1'b0);
        cyc(1'b1);
        checks++;
        if (d0_pv !== 1'b1 || d0_period !== 8'd255 || d0_to !== 1'b0) begin
            errors++;
            $display("FAIL edge_wins: pv=%b period=%0d timeout=%b, need 1/255/0", d0_pv, d0_period, d0_to);
        end
    endtask

    task automatic test_held_high();
        do_reset(1'b1);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 5; i++) begin
                cyc(1'b1);
                if (i == 0 && r > 0) begin
                    checks++;
                    if (d0_pv !== 1'b1 || d0_period !== 8'd8) begin
                        errors++;
                        $display("FAIL held_high r%0d: pv=%b period=%0d, need 1/8", r, d0_pv, d0_period);
                    end
                end
            end
            repeat (3) cyc(1'b0);
        end
        checks++;
        if (n_pv != 3) begin
            errors++;
            $display("FAIL held_high_count: valids=%0d, need 3", n_pv);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        gap(5);
        cyc(1'b1);
        repeat (5) cyc(1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({d0_period, d0_pv, d0_lk, d0_to} !== '0) begin
            errors++;
            $display("FAIL reset_async: got %0d/%b/%b/%b, need 0/0/0/0", d0_period, d0_pv, d0_lk, d0_to);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        gap(4);
        cyc(1'b1);
        checks++;
        if (d0_pv !== 1'b1 || d0_period !== 8'd4 || n_pv != 1) begin
            errors++;
            $display("FAIL reset_resume: pv=%b period=%0d valids=%0d, need 1/4/1", d0_pv, d0_period, n_pv);
        end
    endtask

`ifdef TICK_PERIOD_MINMAX_EN
    task automatic test_minmax();
        do_reset(1'b0);
        gap(9); gap(5); gap(14);
        cyc(1'b1);
        checks++;
        if (d0_min !== 8'd5 || d0_max !== 8'd14) begin
            errors++;
            $display("FAIL minmax_track: min=%0d max=%0d, need 5/14", d0_min, d0_max);
        end
        minmax_clr = 1'b1;
        cyc(1'b0);
        minmax_clr = 1'b0;
        checks++;
        if (d0_min !== 8'hFF || d0_max !== 8'h00) begin
            errors++;
            $display("FAIL minmax_clr: min=%0d max=%0d, need 255/0", d0_min, d0_max);
        end
        repeat (5) cyc(1'b0);
        cyc(1'b1);
        checks++;
        if (d0_min !== 8'd7 || d0_max !== 8'd7) begin
            errors++;
            $display("FAIL minmax_after_clr: min=%0d max=%0d, need 7/7", d0_min, d0_max);
        end
    endtask
`endif

    task automatic test_random();
        int shown;
        shown = 0;
        do_reset(1'b0);
        for (int i = 0; i < 4000; i++) begin
            bit t;
            int ph;
            ph = i % 1000;
            if (ph >= 700 && ph < 980)
                t = 1'b0;
            else if (ph >= 500 && ph < 700)
                t = (ph % 6 == 0) || (ph % 6 == 1 && $urandom_range(0, 3) == 0);
            else
                t = ($urandom_range(0, 5) == 0);
            minmax_clr = ($urandom_range(0, 49) == 0);
            cyc(t);
            checks++;
            if ({d0_period, d0_pv, d0_lk, d0_to} !== {m_period[W-1:0], m_pv, m_lk0, m_to} ||
                {d2_period, d2_pv, d2_lk, d2_to} !== {m_period[W-1:0], m_pv, m_lk2, m_to}) begin
                errors++;
                if (shown < 20)
                    $display("FAIL random cyc%0d: d0=%0d/%b/%b/%b d2=%0d/%b/%b/%b need %0d/%b/%b|%b/%b",
                             i, d0_period, d0_pv, d0_lk, d0_to, d2_period, d2_pv, d2_lk, d2_to,
                             m_period, m_pv, m_lk0, m_lk2, m_to);
                shown++;
            end
`ifdef TICK_PERIOD_MINMAX_EN
            checks++;
            if (d0_min !== m_min[W-1:0] || d0_max !== m_max[W-1:0]) begin
                errors++;
                if (shown < 20)
                    $display("FAIL random_minmax cyc%0d: min=%0d max=%0d need %0d/%0d", i, d0_min, d0_max, m_min, m_max);
                shown++;
            end
`endif
        end
        minmax_clr = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_lock();
        test_timeout();
        test_held_high();
        test_reset_mid();
`ifdef TICK_PERIOD_MINMAX_EN
        test_minmax();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
